// File: rtl/lane_init_sequencer_if.sv
// Control/status bundle between the link controller and the lane init sequencer.
// master = controller side (drives requests), slave = sequencer side (drives status).
interface lane_init_sequencer_if;
    logic       start;
    logic       disconnect;
    logic       sbrx;
    logic       sb_txn_done;
    logic       lane_ready;
    logic [1:0] gen_sel;

    logic [2:0] phase;
    logic       sbtx_high;
    logic       lanes_tx_en;
    logic [1:0] generation_speed;
    logic       phase_5_read_enable;
    logic       training_done;
    logic       timeout_err;

    modport master (
        output start, disconnect, sbrx, sb_txn_done, lane_ready, gen_sel,
        input  phase, sbtx_high, lanes_tx_en, generation_speed,
               phase_5_read_enable, training_done, timeout_err
    );

    modport slave (
        input  start, disconnect, sbrx, sb_txn_done, lane_ready, gen_sel,
        output phase, sbtx_high, lanes_tx_en, generation_speed,
               phase_5_read_enable, training_done, timeout_err
    );
endinterface

// File: rtl/lane_init_sequencer.sv
// Lane initialization sequencer: IDLE -> P1 (sbrx debounce) -> P2/P3 (sideband txns) -> P4 (lane training) -> P5.
// All outputs registered (change with the state edge); optional per-phase timeout via LANE_INIT_PHASE_TIMEOUT_EN.
module lane_init_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lane_init_sequencer_if.slave  link
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_P2   = 3'd2;
    localparam logic [2:0] S_P3   = 3'd3;
    localparam logic [2:0] S_P4   = 3'd4;
    localparam logic [2:0] S_P5   = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd7;

    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] deb_cnt;
    logic [7:0] deb_nxt;
    logic [1:0] speed_nxt;
    logic       launch;
    logic       advance;
    logic       timeout_hit;

`ifdef LANE_INIT_PHASE_TIMEOUT_EN
    localparam logic [15:0] TMR_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] phase_tmr;

    assign timeout_hit = (state inside {[S_P1:S_P4]}) && (phase_tmr == TMR_LIMIT);
`else
    logic [15:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            S_IDLE, S_ERR: begin
                if (link.start) begin
                    launch    = 1'b1;
                    state_nxt = S_P1;
                end
            end
            S_P1: begin
                if (link.sbrx && ((deb_cnt + 8'd1) == DEB_LIMIT)) begin
                    state_nxt = S_P2;
                end
            end
            S_P2: begin
                if (link.sb_txn_done) begin
                    state_nxt = S_P3;
                end
            end
            S_P3: begin
                if (link.sb_txn_done) begin
                    state_nxt = S_P4;
                end
            end
            S_P4: begin
                if (link.lane_ready) begin
                    state_nxt = S_P5;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase

        // A real advance on the same cycle as the timeout beats the timeout.
        advance = (state_nxt != state);
        if (!advance && timeout_hit) begin
            state_nxt = S_ERR;
        end

        if (link.disconnect) begin
            state_nxt = S_IDLE;
            launch    = 1'b0;
        end
    end

    always_comb begin
        deb_nxt = 8'd0;
        if ((state == S_P1) && (state_nxt == S_P1) && link.sbrx) begin
            deb_nxt = deb_cnt + 8'd1;
        end
    end

    // gen_sel=3 has no gen5 meaning here and folds onto gen4.
    always_comb begin
        speed_nxt = 2'd0;
        if (launch) begin
            speed_nxt = (link.gen_sel == 2'd3) ? 2'd2 : link.gen_sel;
        end else if (state_nxt inside {[S_P1:S_P5]}) begin
            speed_nxt = link.generation_speed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= S_IDLE;
            deb_cnt                  <= 8'd0;
            link.sbtx_high           <= 1'b0;
            link.lanes_tx_en         <= 1'b0;
            link.generation_speed    <= 2'd0;
            link.phase_5_read_enable <= 1'b0;
            link.training_done       <= 1'b0;
        end else begin
            state                    <= state_nxt;
            deb_cnt                  <= deb_nxt;
            link.sbtx_high           <= (state_nxt inside {[S_P1:S_P5]});
            link.lanes_tx_en         <= (state_nxt inside {S_P4, S_P5});
            link.generation_speed    <= speed_nxt;
            link.phase_5_read_enable <= (state_nxt == S_P5);
            link.training_done       <= (state_nxt == S_P5);
        end
    end

    assign link.phase = state;

`ifdef LANE_INIT_PHASE_TIMEOUT_EN
    // Timer restarts on every state change and sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_tmr        <= 16'd0;
            link.timeout_err <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                phase_tmr <= 16'd0;
            end else if (phase_tmr != 16'hFFFF) begin
                phase_tmr <= phase_tmr + 16'd1;
            end
            link.timeout_err <= (state_nxt == S_ERR);
        end
    end
`else
    assign link.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_init_sequencer.sv
// Scoreboarded bench: directed phase scenarios plus biased random traffic against a phase-level model.
module tb_lane_init_sequencer;

    localparam int D = 4;
    localparam int T = 16;

    typedef struct packed {
        logic [2:0] phase;
        logic       sbtx;
        logic       lanes;
        logic [1:0] spd;
        logic       p5;
        logic       done;
        logic       terr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lane_init_sequencer_if link();

    lane_init_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    obs_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    int         m_phase = 0;
    int         m_deb   = 0;
    int         m_tmr   = 0;
    logic [1:0] m_spd   = 2'd0;

    function automatic obs_t observed();
        return {link.phase, link.sbtx_high, link.lanes_tx_en, link.generation_speed,
                link.phase_5_read_enable, link.training_done, link.timeout_err};
    endfunction

    function automatic obs_t expect_of(int p, logic [1:0] s);
        obs_t e;
        e.phase = 3'(p);
        e.sbtx  = (p >= 1 && p <= 5);
        e.lanes = (p == 4 || p == 5);
        e.spd   = (p >= 1 && p <= 5) ? s : 2'd0;
        e.p5    = (p == 5);
        e.done  = (p == 5);
        e.terr  = (p == 7);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_deb   = 0;
        m_tmr   = 0;
        m_spd   = 2'd0;
    endtask

    // Phase-level reference: one call per clock edge with the inputs seen at that edge.
    task automatic model_step(input logic st, input logic dis, input logic sb,
                              input logic dn, input logic lr, input logic [1:0] gs);
        int np;
        np = m_phase;
        case (m_phase)
            0, 7: if (st) begin
                np    = 1;
                m_spd = (gs == 2'd3) ? 2'd2 : gs;
            end
            1: if (sb && (m_deb + 1 == D)) np = 2;
            2: if (dn) np = 3;
            3: if (dn) np = 4;
            4: if (lr) np = 5;
            default: np = m_phase;
        endcase
`ifdef LANE_INIT_PHASE_TIMEOUT_EN
        if (np == m_phase && m_phase >= 1 && m_phase <= 4 && m_tmr == T - 1) np = 7;
`endif
        if (dis) np = 0;
        m_deb = (m_phase == 1 && np == 1 && sb) ? m_deb + 1 : 0;
        if (np != m_phase) m_tmr = 0;
        else if (m_tmr < 65535) m_tmr = m_tmr + 1;
        m_phase = np;
    endtask

    task automatic drive(input logic st, input logic dis, input logic sb,
                         input logic dn, input logic lr, input logic [1:0] gs);
        @(negedge clk);
        link.start       = st;
        link.disconnect  = dis;
        link.sbrx        = sb;
        link.sb_txn_done = dn;
        link.lane_ready  = lr;
        link.gen_sel     = gs;
        model_step(st, dis, sb, dn, lr, gs);
        q.push_back(expect_of(m_phase, m_spd));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic debounce(input logic [1:0] gs);
        repeat (D) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, gs);
    endtask

    task automatic go_idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Monitor: every edge produces an output word; compare against the oldest prediction.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("outputs", 32'(observed()), 32'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        link.start       = 1'b0;
        link.disconnect  = 1'b0;
        link.sbrx        = 1'b0;
        link.sb_txn_done = 1'b0;
        link.lane_ready  = 1'b0;
        link.gen_sel     = 2'd0;
        model_reset();
        #1;
        check("reset_outputs", 32'(observed()), 32'd0);
        link.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_holds", 32'(observed()), 32'd0);
        link.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal walk through all phases.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        settle();
        check("nominal_p1", 32'(link.phase), 32'd1);
        debounce(2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        settle();
        check("nominal_p5", 32'(link.phase), 32'd5);
        check("nominal_done", 32'({link.training_done, link.phase_5_read_enable}), 32'd3);
        check("nominal_speed", 32'(link.generation_speed), 32'd1);
        go_idle();

        // Debounce restarts on a zero.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        settle();
        check("debounce_hold", 32'(link.phase), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        settle();
        check("debounce_p2", 32'(link.phase), 32'd2);

        // Disconnect beats a simultaneous sideband completion.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        settle();
        check("disc_priority", 32'(observed()), 32'd0);

        // Speed latched at start, later gen_sel changes ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        debounce(2'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        settle();
        check("speed_p2", 32'(link.generation_speed), 32'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        settle();
        check("speed_p5", 32'(link.generation_speed), 32'd2);
        go_idle();

        // Stall in P3.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        debounce(2'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        repeat (T) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        settle();
`ifdef LANE_INIT_PHASE_TIMEOUT_EN
        check("timeout_phase", 32'(link.phase), 32'd7);
        check("timeout_err", 32'(link.timeout_err), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        settle();
        check("restart_phase", 32'(link.phase), 32'd1);
        check("restart_err", 32'(link.timeout_err), 32'd0);
`else
        check("stall_phase", 32'(link.phase), 32'd3);
        check("stall_err", 32'(link.timeout_err), 32'd0);
`endif
        go_idle();

        // Asynchronous reset in P4.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        debounce(2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        settle();
        check("pre_reset_lanes", 32'(link.lanes_tx_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_lanes", 32'(link.lanes_tx_en), 32'd0);
        check("async_reset_all", 32'(observed()), 32'd0);
        link.start       = 1'b0;
        link.sbrx        = 1'b0;
        link.sb_txn_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Biased random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 19) < 17,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  2'($urandom_range(0, 3)));
        end
        settle();
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lane_init_sequencer.md
LANE_INIT_SEQUENCER -- requirements
Module: lane_init_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive sbrx-high cycles required to leave phase 1; legal 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: per-phase timeout limit for phases 1-4; legal 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; begins initialization when sampled high in IDLE or ERROR.
REQ-006 disconnect  input  1  level; aborts initialization from any state.
REQ-007 sbrx  input  1  sideband receive line, synchronous to clk.
REQ-008 sb_txn_done  input  1  one-cycle pulse; the current sideband transaction has completed.
REQ-009 lane_ready  input  1  level; both lanes report training complete.
REQ-010 gen_sel  input  2  requested speed: 0=gen2, 1=gen3, 2=gen4, 3=gen4.
REQ-011 phase  output  3  current phase: IDLE=0, P1..P5=1..5, ERROR=7.
REQ-012 sbtx_high  output  1  drive sbtx high.
REQ-013 lanes_tx_en  output  1  enable lane_0_tx and lane_1_tx.
REQ-014 generation_speed  output  2  speed latched at start.
REQ-015 phase_5_read_enable  output  1  lane receive data path enabled.
REQ-016 training_done  output  1  initialization complete.
REQ-017 timeout_err  output  1  a phase timed out.

Function
REQ-018 All outputs SHALL be registered; each output SHALL change on the clk edge where the state changes.
REQ-019 IDLE: on start=1, the block SHALL enter P1 and latch gen_sel, mapping 3 to 2.
REQ-020 P1: sbtx_high=1; consecutive sbrx=1 cycles SHALL be counted, with the count cleared when sbrx=0; the block SHALL enter P2 on the cycle the count reaches DEBOUNCE_CYCLES.
REQ-021 P2: sbtx_high=1; the block SHALL enter P3 on sb_txn_done=1.
REQ-022 P3: sbtx_high=1; the block SHALL enter P4 on sb_txn_done=1.
REQ-023 P4: sbtx_high=1 and lanes_tx_en=1; the block SHALL enter P5 on lane_ready=1.
REQ-024 P5: sbtx_high, lanes_tx_en, phase_5_read_enable and training_done SHALL all be 1; the block SHALL remain in P5 until disconnect.
REQ-025 An sb_txn_done pulse SHALL advance at most one phase.
REQ-026 An sb_txn_done pulse in IDLE, P1, P4, P5 or ERROR SHALL be ignored.
REQ-027 disconnect=1 SHALL force IDLE on the next edge from any state and SHALL take priority over every other transition.
REQ-028 In IDLE, disconnect=1 SHALL block start.
REQ-029 ERROR: phase=7, timeout_err=1, all other outputs 0.
REQ-030 From ERROR, start=1 with disconnect=0 SHALL enter P1 and clear timeout_err.
REQ-031 The phase timer SHALL be 16 bits and SHALL clear on every state change.
REQ-032 The phase timer SHALL saturate and never wrap.
REQ-033 The debounce counter SHALL be 8 bits and SHALL clear on entry to P1.
REQ-034 If an advance condition and the timeout occur on the same cycle, the advance SHALL win.

Reset
REQ-035 When rst_n=0: state SHALL be IDLE, phase=0, all 1-bit outputs 0, generation_speed=0, and both counters 0.
REQ-036 Deassertion of rst_n SHALL take effect on the first following clk edge.
REQ-037 Reset asserted mid-sequence SHALL abort the sequence, with no output glitch beyond the asynchronous clear.

Configuration
REQ-038 With macro LANE_INIT_PHASE_TIMEOUT_EN defined, a phase timer value of TIMEOUT_CYCLES-1 in P1-P4 SHALL enter ERROR on the next edge.
REQ-039 Without LANE_INIT_PHASE_TIMEOUT_EN, the phase timer and ERROR state SHALL be absent, timeout_err SHALL be tied 0, and phases SHALL wait indefinitely.

Verification
REQ-040 Nominal sequence: start, sbrx high 4 cycles, two sb_txn_done pulses, lane_ready -> phase steps 0,1,2,3,4,5, training_done=1, phase_5_read_enable=1.
REQ-041 Debounce restart: sbrx pattern 1,1,1,0,1,1,1,1 in P1 -> P2 entered only after the final fourth consecutive 1.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=16): stall in P3 for 16 cycles -> phase=7, timeout_err=1; then start -> phase=1, timeout_err=0.
REQ-043 Disconnect priority: disconnect and sb_txn_done both pulsed in P2 -> phase=0, all outputs 0.
REQ-044 Speed latch: gen_sel=3 at start, changed to 0 in P2 -> generation_speed=2 throughout the sequence.
REQ-045 Reset mid-P4: rst_n low -> lanes_tx_en=0 immediately and phase=0.
